// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad event scanner: line indices, event field layout.
// Line index = bit position in {joystick, buttons}.
package gamepad_pkg;

  localparam int NUM_LINES = 12;

  localparam int IDX_DOWN   = 11;
  localparam int IDX_UP     = 10;
  localparam int IDX_RIGHT  = 9;
  localparam int IDX_LEFT   = 8;
  localparam int IDX_X      = 7;
  localparam int IDX_Y      = 6;
  localparam int IDX_A      = 5;
  localparam int IDX_B      = 4;
  localparam int IDX_TR     = 3;
  localparam int IDX_TL     = 2;
  localparam int IDX_START  = 1;
  localparam int IDX_SELECT = 0;

  localparam int EV_W         = 16;
  localparam int EV_PRESS_POS = 15;
  localparam int EV_IDX_LSB   = 11;
  localparam int EV_IDX_W     = 4;
  localparam int EV_TS_LSB    = 0;
  localparam int EV_TS_W      = 11;

  typedef struct packed {
    logic                press;
    logic [EV_IDX_W-1:0] idx;
    logic [EV_TS_W-1:0]  ts;
  } event_t;

  function automatic logic [EV_W-1:0] pack_event(input logic press,
                                                 input logic [EV_IDX_W-1:0] idx,
                                                 input logic [EV_TS_W-1:0] ts);
    event_t e;
    e.press = press;
    e.idx   = idx;
    e.ts    = ts;
    return e;
  endfunction

endpackage

// File: rtl/gamepad_event_scanner_if.sv
// Event queue read port. Handshake: ev_data is meaningful whenever ev_valid=1;
// the consumer raises ev_pop for one cycle to retire the head; ev_pop with ev_valid=0 is ignored.
interface gamepad_event_scanner_if;
  import gamepad_pkg::*;

  logic            ev_valid;
  logic [EV_W-1:0] ev_data;
  logic            ev_pop;

  modport master (output ev_valid, output ev_data, input ev_pop);
  modport slave  (input ev_valid, input ev_data, output ev_pop);
endinterface

// File: rtl/gp_event_fifo.sv
// First-word-fall-through event queue; push at full is accepted only when a pop frees a slot.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module gp_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Forced to zero when empty so the head reads 0 out of reset.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/gamepad_event_scanner.sv
// Scans 12 active-low pad lines, debounces them on a 1 ms tick and queues press/release events.
// Define GAMEPAD_TIMESTAMP_EN to stamp events with a free-running ms counter (otherwise ts=0).
module gamepad_event_scanner
  import gamepad_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              joystick,
  input  logic [7:0]              buttons,
  output logic [NUM_LINES-1:0]    state,
  gamepad_event_scanner_if.master ev,
  input  logic                    irq_en,
  output logic                    irq,
  output logic                    ovf,
  input  logic                    ovf_clr
);
  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_MS);

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 tick;
  logic [NUM_LINES-1:0] sync1_q, sync2_q;
  logic [NUM_LINES-1:0] state_q, state_d, pending_q, pending_d, toggle, clear_mask;
  logic [3:0]           cnt_q [NUM_LINES];
  logic [3:0]           cnt_d [NUM_LINES];
  logic [EV_IDX_W-1:0]  sel_idx;
  logic                 sel_press, push, pop, overflow;
  logic [EV_TS_W-1:0]   ts;
  logic [EV_W-1:0]      head_data;
  logic                 fifo_full, fifo_empty;
  logic                 irq_q, ovf_q;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // A line toggles only after DEBOUNCE_MS consecutive ticks disagreeing with its level.
  always_comb begin
    state_d = state_q;
    toggle  = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] + 4'd1 == DB_LIMIT) begin
          cnt_d[i]   = '0;
          state_d[i] = ~state_q[i];
          toggle[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Drain one pending line per cycle, lowest index first (downward scan: last hit wins).
  always_comb begin
    sel_idx    = '0;
    sel_press  = 1'b0;
    clear_mask = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx    = EV_IDX_W'(i);
        sel_press  = state_q[i];
        clear_mask = '0;
        clear_mask[i] = 1'b1;
      end
    end
  end

  assign push      = |pending_q;
  assign pending_d = (pending_q & ~clear_mask) | toggle;
  assign pop       = ev.ev_pop & ~fifo_empty;
  assign overflow  = push & fifo_full & ~pop;

`ifdef GAMEPAD_TIMESTAMP_EN
  logic [EV_TS_W-1:0] ms_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ms_q <= '0;
    else if (tick) ms_q <= ms_q + 1'b1;
  end
  assign ts = ms_q;
`else
  assign ts = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) cnt_q[i] <= '0;
    end else begin
      presc_q   <= presc_d;
      sync1_q   <= ~{joystick, buttons};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_q     <= ~fifo_empty & irq_en;
      ovf_q     <= (ovf_q & ~ovf_clr) | overflow;
      for (int i = 0; i < NUM_LINES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  gp_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (pack_event(sel_press, sel_idx, ts)),
    .pop_i       (ev.ev_pop),
    .pop_data_o  (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign ev.ev_valid = ~fifo_empty;
  assign ev.ev_data  = head_data;
  assign state       = state_q;
  assign irq         = irq_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_gamepad_event_scanner.sv
// Directed bench for gamepad_event_scanner (CLK_HZ=10000 -> tick every 10 cycles, DEBOUNCE_MS=3).
// Expected events go into exp_q at stimulus time; a forked monitor pops and compares them.
module tb_gamepad_event_scanner;
  import gamepad_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  joystick;
  logic [7:0]  buttons;
  logic [11:0] state;
  logic        irq_en, irq, ovf, ovf_clr;
  logic        blind_pop;
  int          cyc;
  int          checks = 0;
  int          failures = 0;
  int          pop_req = 0;
  int          pop_done = 0;
  logic [15:0] exp_q[$];

  gamepad_event_scanner_if ev_if ();

  gamepad_event_scanner #(
    .CLK_HZ      (10000),
    .DEBOUNCE_MS (3),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .joystick (joystick),
    .buttons  (buttons),
    .state    (state),
    .ev       (ev_if),
    .irq_en   (irq_en),
    .irq      (irq),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  // Clock and a cycle counter that mirrors the prescaler: ticks act on posedges cyc=10,20,...
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [10:0] ts_of(input int ms);
`ifdef GAMEPAD_TIMESTAMP_EN
    return 11'(ms);
`else
    return 11'(ms * 0);
`endif
  endfunction

  function automatic logic [15:0] mk_ev(input logic press, input int idx, input int ms);
    return {press, 4'(idx), ts_of(ms)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_line(input int idx, input logic pressed);
    if (idx >= 8) joystick[idx-8] = ~pressed;
    else          buttons[idx]    = ~pressed;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    joystick  = 4'hF;
    buttons   = 8'hFF;
    ovf_clr   = 1'b0;
    blind_pop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    exp_q.delete();
    pop_req = pop_done;
    rst_n   = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && pop_done < pop_req; k++) @(posedge clk);
    #2;
    check(name, 16'(pop_req - pop_done), 16'h0000);
  endtask

  // Monitor: pops whenever a pop is owed and the head is valid, comparing against exp_q.
  task automatic monitor_loop();
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (ev_if.ev_valid && pop_done < pop_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got=%h expected=none (t=%0t)", ev_if.ev_data, $time);
        end else begin
          exp = exp_q.pop_front();
          if (ev_if.ev_data !== exp) begin
            failures++;
            $display("FAIL ev_data got=%h expected=%h (t=%0t)", ev_if.ev_data, exp, $time);
          end
        end
        pop_done++;
        ev_if.ev_pop = 1'b1;
      end else begin
        ev_if.ev_pop = blind_pop;
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    joystick     = 4'hF;
    buttons      = 8'hFF;
    irq_en       = 1'b1;
    ovf_clr      = 1'b0;
    blind_pop    = 1'b0;
    ev_if.ev_pop = 1'b0;
    fork
      monitor_loop();
      begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", 16'(state), 16'h0000);
    check("rst_ev_valid", 16'(ev_if.ev_valid), 16'h0000);
    check("rst_ev_data", ev_if.ev_data, 16'h0000);
    check("rst_irq", 16'(irq), 16'h0000);
    check("rst_ovf", 16'(ovf), 16'h0000);

    // Hold A: toggles on the 3rd tick after release, one press event, irq follows
    do_reset();
    irq_en = 1'b1;
    wait_cyc(2);
    set_line(IDX_A, 1'b1);
    exp_q.push_back(mk_ev(1'b1, IDX_A, 3));
    wait_cyc(29);
    check("a_before_3rd_tick", 16'(state), 16'h0000);
    wait_cyc(30);
    check("a_state", 16'(state), 16'h0020);
    wait_cyc(33);
    check("a_ev_valid", 16'(ev_if.ev_valid), 16'h0001);
    check("a_irq", 16'(irq), 16'h0001);
    pop_req += 1;
    wait_drain("a_drain");
    wait_cyc(42);
    check("a_single_event", 16'(ev_if.ev_valid), 16'h0000);
    check("a_irq_low", 16'(irq), 16'h0000);

    // START bouncing every 7 cycles never holds 3 equal ticks
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      wait_cyc(7 * k);
      buttons[IDX_START] = ~buttons[IDX_START];
    end
    wait_cyc(130);
    check("bounce_state", 16'(state), 16'h0000);
    check("bounce_no_event", 16'(ev_if.ev_valid), 16'h0000);

    // UP and X on the same tick: index 7 first, then 10, same timestamp
    do_reset();
    wait_cyc(2);
    set_line(IDX_UP, 1'b1);
    set_line(IDX_X, 1'b1);
    exp_q.push_back(mk_ev(1'b1, IDX_X, 3));
    exp_q.push_back(mk_ev(1'b1, IDX_UP, 3));
    wait_cyc(30);
    check("upx_state", 16'(state), 16'h0480);
    pop_req += 2;
    wait_drain("upx_drain");
    wait_cyc(45);
    check("upx_empty", 16'(ev_if.ev_valid), 16'h0000);

    // Ten edges, no pops: first 8 kept, ovf sticky, clear, pop on empty ignored
    do_reset();
    irq_en = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < 10; i++) set_line(i, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(mk_ev(1'b1, i, 3));
    wait_cyc(41);
    check("ovf_set", 16'(ovf), 16'h0001);
    check("ovf_ev_valid", 16'(ev_if.ev_valid), 16'h0001);
    check("irq_disabled", 16'(irq), 16'h0000);
    irq_en = 1'b1;
    wait_cyc(43);
    check("irq_enabled", 16'(irq), 16'h0001);
    check("ovf_still_set", 16'(ovf), 16'h0001);
    ovf_clr = 1'b1;
    wait_cyc(44);
    ovf_clr = 1'b0;
    check("ovf_cleared", 16'(ovf), 16'h0000);
    pop_req += 8;
    wait_drain("ovf_drain");
    check("ovf_empty", 16'(ev_if.ev_valid), 16'h0000);
    blind_pop = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    blind_pop = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("empty_pop_valid", 16'(ev_if.ev_valid), 16'h0000);
    check("empty_pop_data", ev_if.ev_data, 16'h0000);
    check("empty_pop_ovf", 16'(ovf), 16'h0000);
    wait_cyc(70);
    set_line(IDX_SELECT, 1'b0);
    exp_q.push_back(mk_ev(1'b0, IDX_SELECT, 10));
    wait_cyc(103);
    check("release_ev_valid", 16'(ev_if.ev_valid), 16'h0001);
    pop_req += 1;
    wait_drain("release_drain");
    wait_cyc(110);
    check("release_empty", 16'(ev_if.ev_valid), 16'h0000);

    // Push and pop together at full: nothing dropped, order preserved
    do_reset();
    wait_cyc(2);
    for (int i = 0; i < 9; i++) set_line(i, 1'b1);
    for (int i = 0; i < 9; i++) exp_q.push_back(mk_ev(1'b1, i, 3));
    wait_cyc(38);
    pop_req += 1;
    wait_cyc(41);
    check("full_pp_ovf", 16'(ovf), 16'h0000);
    check("full_pp_valid", 16'(ev_if.ev_valid), 16'h0001);
    pop_req += 8;
    wait_drain("full_pp_drain");
    check("full_pp_empty", 16'(ev_if.ev_valid), 16'h0000);

    // Asynchronous reset with events queued
    do_reset();
    irq_en = 1'b1;
    wait_cyc(2);
    set_line(IDX_TL, 1'b1);
    set_line(IDX_B, 1'b1);
    set_line(IDX_Y, 1'b1);
    wait_cyc(35);
    check("pre_rst_valid", 16'(ev_if.ev_valid), 16'h0001);
    check("pre_rst_state", 16'(state), 16'h0054);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 16'(ev_if.ev_valid), 16'h0000);
    check("async_rst_irq", 16'(irq), 16'h0000);
    check("async_rst_state", 16'(state), 16'h0000);
    check("async_rst_data", ev_if.ev_data, 16'h0000);
    do_reset();
    wait_cyc(40);
    check("post_rst_valid", 16'(ev_if.ev_valid), 16'h0000);
    check("post_rst_state", 16'(state), 16'h0000);

    check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gamepad_event_scanner.md
GAMEPAD_EVENT_SCANNER -- requirements
Module: gamepad_event_scanner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the clk frequency used to derive a 1 ms tick.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, range 1..15, meaning the number of consecutive equal tick samples needed to accept a new level.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, a power of two, meaning the event queue depth.
REQ-004 Port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port joystick, input, 4 bits: raw pad lines {DOWN,UP,RIGHT,LEFT}, active-low, asynchronous.
REQ-007 Port buttons, input, 8 bits: raw pad lines {X,Y,A,B,TR,TL,START,SELECT}, active-low, asynchronous.
REQ-008 Port state, output, 12 bits: debounced levels, 1 = pressed; index = {joystick,buttons} bit position.
REQ-009 Port ev_valid, output, 1 bit: the event queue is non-empty.
REQ-010 Port ev_data, output, 16 bits: head event, formatted [15] press=1/release=0, [14:11] index 0..11, [10:0] timestamp.
REQ-011 Port ev_pop, input, 1 bit: a one-cycle request that removes the head event.
REQ-012 Port irq_en, input, 1 bit: interrupt enable.
REQ-013 Port irq, output, 1 bit: interrupt, equal to ev_valid AND irq_en, registered.
REQ-014 Port ovf, output, 1 bit: sticky overflow flag.
REQ-015 Port ovf_clr, input, 1 bit: a one-cycle request that clears ovf.

Function
REQ-016 SHALL pass each raw line through a 2-FF synchroniser, then invert it so that 1 = pressed.
REQ-017 SHALL generate a one-cycle tick every CLK_HZ/1000 clk cycles from a free-running prescaler that wraps to 0.
REQ-018 Debounce, per line: on each tick, if the synchronised value equals state[i], the line's 4-bit counter SHALL clear; otherwise the counter SHALL increment, and on reaching DEBOUNCE_MS state[i] SHALL toggle and the counter SHALL clear.
REQ-019 On each toggle of state[i], pending[i] SHALL be set in the same cycle; several lines may toggle on the same tick.
REQ-020 Each clk cycle, the lowest-index set pending bit SHALL be cleared and one event pushed: press = new state[i], index = i, timestamp = the 11-bit ms counter.
REQ-021 The ms counter SHALL increment on each tick and wrap 2047 -> 0.
REQ-022 The FIFO SHALL be first-word fall-through: ev_data is valid whenever ev_valid = 1, and events leave in push order.
REQ-023 A pop with ev_valid = 0 SHALL be ignored.
REQ-024 A simultaneous push and pop SHALL both take effect; the occupancy count SHALL be unchanged, including when the FIFO is full.
REQ-025 A push when the FIFO is full with no pop in the same cycle SHALL drop the event, leave the FIFO unchanged, and set ovf.
REQ-026 ovf SHALL stay set until ovf_clr; if ovf_clr and an overflow occur in the same cycle, ovf SHALL end set.
REQ-027 Latency from a tick that toggles a state bit to that event appearing at the FIFO head of an empty FIFO SHALL be at most 13 cycles; irq follows ev_valid one cycle later.

Reset
REQ-028 While rst_n = 0, the following SHALL be 0: state, pending, all debounce counters, the prescaler, the ms counter, the synchronisers (0 = released after inversion), FIFO pointers and count, ev_valid, irq, ovf; ev_data SHALL be 16'h0000.
REQ-029 Reset asserted mid-operation SHALL discard all queued and pending events; the first post-reset tick occurs CLK_HZ/1000 cycles after release.

Configuration
REQ-030 Macro GAMEPAD_TIMESTAMP_EN: when defined, ev_data[10:0] SHALL carry the ms counter; when undefined, ev_data[10:0] SHALL be 0 and the ms counter SHALL be omitted from the design.

Structure
REQ-031 Package gamepad_pkg SHALL hold: button index constants (DOWN=11 .. SELECT=0), the event field positions and widths, and NUM_LINES=12.
REQ-032 The queue SHALL be the sub-module gp_event_fifo (parameterised width and depth, FWFT, with full, empty, push, pop); all other logic stays in the top module.

Verification (bench CLK_HZ=10000, giving a tick every 10 cycles; DEBOUNCE_MS=3)
REQ-033 Hold A low 40 cycles -> state[5]=1 after the 3rd tick; exactly one event 16'h8000|(5<<11)|ts; irq=1 with irq_en=1.
REQ-034 Toggle START every 7 cycles for 100 cycles -> state[1] stays 0 and no event is queued.
REQ-035 Press UP and X on the same tick -> two events, index 7 then index 10, with equal timestamps.
REQ-036 Generate 10 edges with no pops, FIFO_DEPTH=8 -> 8 events are kept and ovf=1; ovf_clr -> ovf=0; pop on empty -> no change.
REQ-037 Pop and push in the same cycle at full -> count stays 8, and order is preserved.
REQ-038 Assert rst_n=0 with 3 events queued -> ev_valid=0, irq=0, and state=0 immediately (asynchronously).
